// File: rtl/mbist_march_fsm_pkg.sv
// ---------------------------------------------------------------------------
// mbist_march_fsm_pkg
//  Shared definitions for the MBIST march sequencer:
//   - op slot layout inside a stimulus word ({valid,we,inv} per slot)
//   - sequencer state encoding
//   - helpers that derive stimulus width and direction bit position
// ---------------------------------------------------------------------------
package mbist_march_fsm_pkg;

    localparam int BIST_OP_CNT_DEF = 5;
    localparam int OP_FIELD_WD     = 3;

    // One op slot; packed so an array of slots overlays the stimulus word
    // with slot k at bits [3k+2:3k].
    typedef struct packed {
        logic valid;
        logic we;
        logic inv;
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXEC,
        ST_NEXT_STI,
        ST_DONE
    } state_t;

    function automatic int sti_wd(input int op_cnt);
        return OP_FIELD_WD * op_cnt + 1;
    endfunction

    // Direction flag sits just above the last op slot (1 = march down).
    function automatic int dir_bit(input int op_cnt);
        return OP_FIELD_WD * op_cnt;
    endfunction

endpackage

// File: rtl/mbist_march_fsm_addr_gen.sv
// ---------------------------------------------------------------------------
// mbist_march_fsm_addr_gen
//  Loadable up/down address counter for the march.
//  Ports:
//   clk, rst_n  clock / async active-low reset
//   load        load START (up) or END (down); wins over step
//   down        count direction, 1 = decrement
//   step        advance one address
//   hold        freezes the counter even when step is set
//   addr        current march address
//   at_term     addr is at the end of the range for the current direction
// ---------------------------------------------------------------------------
module mbist_march_fsm_addr_gen #(
    parameter int                 ADDR_WD    = 9,
    parameter logic [ADDR_WD-1:0] ADDR_START = '0,
    parameter logic [ADDR_WD-1:0] ADDR_END   = '1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               down,
    input  logic               step,
    input  logic               hold,
    output logic [ADDR_WD-1:0] addr,
    output logic               at_term
);

    localparam logic [ADDR_WD-1:0] ADDR_ONE = ADDR_WD'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (load) begin
            addr <= down ? ADDR_END : ADDR_START;
        end else if (step && !hold) begin
            addr <= down ? (addr - ADDR_ONE) : (addr + ADDR_ONE);
        end
    end

    // The FSM never steps once at_term is set, so the counter cannot wrap.
    assign at_term = down ? (addr == ADDR_START) : (addr == ADDR_END);

endmodule

// File: rtl/mbist_march_fsm.sv
// ---------------------------------------------------------------------------
// mbist_march_fsm
//  MBIST march sequencer. For each stimulus from the stimulus selector it
//  walks the address range once (up or down) and issues the stimulus' valid
//  op slots at every address, then pulses run to advance the selector.
//  Ports:
//   clk, rst_n      clock / async active-low reset
//   bist_en         level: 1 start/keep running, 0 abort or clear done
//   scan_shift      scan mode, forces IDLE
//   stimulus        current stimulus word {dir, op[OP_CNT-1] .. op[0]}
//   last_stimulus   current stimulus is the final one
//   run             1-cycle pulse advancing the stimulus selector
//   mem_hold        memory stall, freezes the current op
//   cmp_err         read-compare mismatch from the memory wrapper
//   op_valid/op_we/op_inv/op_addr   op presented to the memory port
//   bist_busy       sequencer active (not IDLE/DONE)
//   bist_done       test complete, held until bist_en drops
//   bist_error      sticky compare error
//   err_addr        op_addr of the first compare error
//
//  state       | meaning
//  ------------+----------------------------------------------------------
//  ST_IDLE     | waiting for bist_en with scan_shift low
//  ST_LOAD     | new stimulus valid; load start address, pick slot 0
//  ST_EXEC     | presenting ops, stepping slots and addresses
//  ST_NEXT_STI | run pulse out; go to LOAD or DONE on last_stimulus
//  ST_DONE     | bist_done high until bist_en drops
// ---------------------------------------------------------------------------
module mbist_march_fsm
    import mbist_march_fsm_pkg::*;
#(
    parameter int BIST_ADDR_WD     = 9,
    parameter int BIST_ADDR_START  = 0,
    parameter int BIST_ADDR_END    = 2**BIST_ADDR_WD - 1,
    parameter int BIST_OP_CNT      = BIST_OP_CNT_DEF,
    parameter int BIST_STI_WD      = sti_wd(BIST_OP_CNT),
    parameter int BIST_STOP_ON_ERR = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    bist_en,
    input  logic                    scan_shift,
    input  logic [BIST_STI_WD-1:0]  stimulus,
    input  logic                    last_stimulus,
    output logic                    run,
    input  logic                    mem_hold,
    input  logic                    cmp_err,
    output logic                    op_valid,
    output logic                    op_we,
    output logic                    op_inv,
    output logic [BIST_ADDR_WD-1:0] op_addr,
    output logic                    bist_busy,
    output logic                    bist_done,
    output logic                    bist_error,
    output logic [BIST_ADDR_WD-1:0] err_addr
);

    localparam int               IDX_WD   = (BIST_OP_CNT > 1) ? $clog2(BIST_OP_CNT) : 1;
    localparam logic [IDX_WD-1:0] IDX_LAST = IDX_WD'(BIST_OP_CNT - 1);
    localparam logic [IDX_WD-1:0] IDX_ONE  = IDX_WD'(1);
    localparam bit               STOP_ERR = (BIST_STOP_ON_ERR != 0);

    state_t                 state;
    logic [IDX_WD-1:0]      op_idx;
    logic [IDX_WD-1:0]      idx_nxt;
    op_t [BIST_OP_CNT-1:0]  slots;
    logic                   dir_down;
    logic                   last_slot;
    logic                   elem_end;
    logic                   at_term;
    logic                   abort;
    logic                   err_stop;
    logic                   ag_load;
    logic                   ag_step;

    assign slots    = stimulus[BIST_STI_WD-2:0];
    assign dir_down = stimulus[dir_bit(BIST_OP_CNT)];
    assign abort    = scan_shift | ~bist_en;
    assign err_stop = cmp_err & STOP_ERR;

    // idx_nxt is clamped to 0 on the last slot so slots[] is never indexed
    // past its end; last_slot already terminates the element there.
    assign last_slot = (op_idx == IDX_LAST);
    assign idx_nxt   = last_slot ? '0 : (op_idx + IDX_ONE);
    assign elem_end  = last_slot | ~slots[idx_nxt].valid;

    assign ag_load = (state == ST_LOAD);
    assign ag_step = (state == ST_EXEC) & ~abort & ~err_stop & elem_end & ~at_term;

    mbist_march_fsm_addr_gen #(
        .ADDR_WD    (BIST_ADDR_WD),
        .ADDR_START (BIST_ADDR_WD'(BIST_ADDR_START)),
        .ADDR_END   (BIST_ADDR_WD'(BIST_ADDR_END))
    ) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (ag_load),
        .down    (dir_down),
        .step    (ag_step),
        .hold    (mem_hold),
        .addr    (op_addr),
        .at_term (at_term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            op_idx     <= '0;
            op_valid   <= 1'b0;
            op_we      <= 1'b0;
            op_inv     <= 1'b0;
            run        <= 1'b0;
            bist_busy  <= 1'b0;
            bist_done  <= 1'b0;
            bist_error <= 1'b0;
            err_addr   <= '0;
        end else begin
            run <= 1'b0;
            if (state != ST_IDLE && abort) begin
                // Leaving DONE this way is also how bist_done gets cleared.
                state     <= ST_IDLE;
                op_idx    <= '0;
                op_valid  <= 1'b0;
                bist_busy <= 1'b0;
                bist_done <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bist_en && !scan_shift) begin
                            state      <= ST_LOAD;
                            bist_busy  <= 1'b1;
                            bist_error <= 1'b0;
                            err_addr   <= '0;
                        end
                    end

                    ST_LOAD: begin
                        op_idx <= '0;
                        op_we  <= slots[0].we;
                        op_inv <= slots[0].inv;
                        if (slots[0].valid) begin
                            state    <= ST_EXEC;
                            op_valid <= 1'b1;
                        end else begin
                            state <= ST_NEXT_STI;
                            run   <= 1'b1;
                        end
                    end

                    ST_EXEC: begin
                        if (cmp_err) begin
                            bist_error <= 1'b1;
                            if (!bist_error) begin
                                err_addr <= op_addr;
                            end
                        end
                        if (err_stop) begin
                            state     <= ST_DONE;
                            op_valid  <= 1'b0;
                            bist_busy <= 1'b0;
                            bist_done <= 1'b1;
                        end else if (!mem_hold) begin
                            if (!elem_end) begin
                                op_idx <= idx_nxt;
                                op_we  <= slots[idx_nxt].we;
                                op_inv <= slots[idx_nxt].inv;
                            end else if (at_term) begin
                                state    <= ST_NEXT_STI;
                                op_valid <= 1'b0;
                                run      <= 1'b1;
                            end else begin
                                // address counter steps on this same edge
                                op_idx <= '0;
                                op_we  <= slots[0].we;
                                op_inv <= slots[0].inv;
                            end
                        end
                    end

                    ST_NEXT_STI: begin
                        // last_stimulus still describes the stimulus just
                        // finished; the selector updates on this edge.
                        if (last_stimulus) begin
                            state     <= ST_DONE;
                            bist_busy <= 1'b0;
                            bist_done <= 1'b1;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end

                    ST_DONE: begin
                        state <= ST_DONE;
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mbist_march_fsm.sv
module tb_mbist_march_fsm;

    localparam int AW   = 3;
    localparam int OPC  = 5;
    localparam int SW   = 3 * OPC + 1;
    localparam int AMAX = 7;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_W0   = 3'b110;
    localparam logic [2:0] OP_R0   = 3'b100;
    localparam logic [2:0] OP_W1   = 3'b111;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic          inv;
    } exp_op_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bist_en = 1'b0;
    logic scan_shift = 1'b0;
    logic mem_hold = 1'b0;
    logic cmp_err = 1'b0;
    logic sel_b_dut = 1'b0;

    logic [SW-1:0] sti_tab [4];
    int            num_sti = 1;
    int            sel_a, sel_b;
    logic [SW-1:0] stim_a, stim_b;
    logic          last_a, last_b;

    logic          run_a, ov_a, we_a, inv_a, busy_a, done_a, err_a;
    logic [AW-1:0] addr_a, eaddr_a;
    logic          run_b, ov_b, we_b, inv_b, busy_b, done_b, err_b;
    logic [AW-1:0] addr_b, eaddr_b;

    logic          m_run, m_valid, m_we, m_inv, m_busy, m_done, m_error;
    logic [AW-1:0] m_addr, m_err_addr;

    int n_checks = 0;
    int n_fail   = 0;
    exp_op_t exp_q[$];

    always #5 clk = ~clk;

    // Stimulus selector models: registered index advanced by run, wraps after last.
    assign stim_a = sti_tab[sel_a];
    assign stim_b = sti_tab[sel_b];
    assign last_a = (sel_a == num_sti - 1);
    assign last_b = (sel_b == num_sti - 1);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sel_a <= 0;
        else if (run_a) sel_a <= last_a ? 0 : sel_a + 1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sel_b <= 0;
        else if (run_b) sel_b <= last_b ? 0 : sel_b + 1;
    end

    mbist_march_fsm #(
        .BIST_ADDR_WD(AW), .BIST_ADDR_START(0), .BIST_ADDR_END(AMAX),
        .BIST_OP_CNT(OPC), .BIST_STI_WD(SW), .BIST_STOP_ON_ERR(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bist_en(bist_en), .scan_shift(scan_shift),
        .stimulus(stim_a), .last_stimulus(last_a), .run(run_a),
        .mem_hold(mem_hold), .cmp_err(cmp_err),
        .op_valid(ov_a), .op_we(we_a), .op_inv(inv_a), .op_addr(addr_a),
        .bist_busy(busy_a), .bist_done(done_a), .bist_error(err_a), .err_addr(eaddr_a)
    );

    mbist_march_fsm #(
        .BIST_ADDR_WD(AW), .BIST_ADDR_START(0), .BIST_ADDR_END(AMAX),
        .BIST_OP_CNT(OPC), .BIST_STI_WD(SW), .BIST_STOP_ON_ERR(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bist_en(bist_en), .scan_shift(scan_shift),
        .stimulus(stim_b), .last_stimulus(last_b), .run(run_b),
        .mem_hold(mem_hold), .cmp_err(cmp_err),
        .op_valid(ov_b), .op_we(we_b), .op_inv(inv_b), .op_addr(addr_b),
        .bist_busy(busy_b), .bist_done(done_b), .bist_error(err_b), .err_addr(eaddr_b)
    );

    assign m_run      = sel_b_dut ? run_b   : run_a;
    assign m_valid    = sel_b_dut ? ov_b    : ov_a;
    assign m_we       = sel_b_dut ? we_b    : we_a;
    assign m_inv      = sel_b_dut ? inv_b   : inv_a;
    assign m_addr     = sel_b_dut ? addr_b  : addr_a;
    assign m_busy     = sel_b_dut ? busy_b  : busy_a;
    assign m_done     = sel_b_dut ? done_b  : done_a;
    assign m_error    = sel_b_dut ? err_b   : err_a;
    assign m_err_addr = sel_b_dut ? eaddr_b : eaddr_a;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [SW-1:0] sti2(input logic dir, input logic [2:0] o0, input logic [2:0] o1);
        return {dir, 9'b0, o1, o0};
    endfunction

    // Expected op stream of a complete march over the current stimulus table.
    task automatic build_exp();
        logic [SW-1:0] st;
        int nv;
        int ad;
        exp_op_t e;
        exp_q.delete();
        for (int s = 0; s < num_sti; s++) begin
            st = sti_tab[s];
            nv = 0;
            for (int k = 0; k < OPC; k++) begin
                if (!st[3*k+2]) break;
                nv = k + 1;
            end
            for (int a = 0; a <= AMAX; a++) begin
                ad = st[SW-1] ? AMAX - a : a;
                for (int j = 0; j < nv; j++) begin
                    e.addr = ad[AW-1:0];
                    e.we   = st[3*j+1];
                    e.inv  = st[3*j];
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    // Starts a test at a negedge and samples each following negedge until done.
    // hold_k/err_k* are indices into the expected op stream (-1 = unused).
    task automatic march(input logic use_b, input int hold_k, input int hold_len,
                         input int err_k0, input int err_k1,
                         output int cyc, output int nops, output int nruns, output int first);
        int k;
        int held;
        k = 0; held = 0; cyc = 0; nruns = 0; first = 0;
        build_exp();
        sel_b_dut = use_b;
        bist_en = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            mem_hold = 1'b0;
            cmp_err  = 1'b0;
            cyc = c;
            if (m_run) nruns++;
            if (m_done) break;
            if (m_valid) begin
                if (first == 0) first = c;
                if (k < exp_q.size()) begin
                    check_eq("op_addr", m_addr, exp_q[k].addr);
                    check_eq("op_we", m_we, exp_q[k].we);
                    check_eq("op_inv", m_inv, exp_q[k].inv);
                end else begin
                    check_eq("op_overrun", k, exp_q.size());
                end
                if (k == err_k0 || k == err_k1) cmp_err = 1'b1;
                if (k == hold_k && held < hold_len) begin
                    mem_hold = 1'b1;
                    held++;
                end else begin
                    k++;
                end
            end
        end
        check_eq("done_seen", m_done, 1);
        nops = k;
    endtask

    task automatic end_test();
        bist_en = 1'b0;
        @(negedge clk);
        check_eq("end_done_clr", m_done, 0);
        check_eq("end_busy", m_busy, 0);
    endtask

    int cyc, nops, nruns, first;

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_op_valid", ov_a, 0);
        check_eq("rst_run", run_a, 0);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_done", done_a, 0);
        check_eq("rst_error", err_a, 0);
        check_eq("rst_err_addr", eaddr_a, 0);
        check_eq("rst_op_addr", addr_a, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: two stimuli, up W0,R0 then down R0,W1
        sti_tab[0] = sti2(1'b0, OP_W0, OP_R0);
        sti_tab[1] = sti2(1'b1, OP_R0, OP_W1);
        num_sti = 2;
        march(1'b0, -1, 0, -1, -1, cyc, nops, nruns, first);
        check_eq("t1_cycles", cyc, 37);
        check_eq("t1_ops", nops, 32);
        check_eq("t1_runs", nruns, 2);
        check_eq("t1_latency", first, 2);
        check_eq("t1_error", m_error, 0);
        check_eq("t1_valid_in_done", m_valid, 0);
        end_test();

        // 2: three-cycle stall on addr 4 op1
        march(1'b0, 9, 3, -1, -1, cyc, nops, nruns, first);
        check_eq("t2_cycles", cyc, 40);
        check_eq("t2_ops", nops, 32);
        check_eq("t2_runs", nruns, 2);
        end_test();

        // 3: stop on first error at addr 5
        march(1'b0, -1, 0, 11, -1, cyc, nops, nruns, first);
        check_eq("t3_cycles", cyc, 14);
        check_eq("t3_ops", nops, 12);
        check_eq("t3_runs", nruns, 0);
        check_eq("t3_error", m_error, 1);
        check_eq("t3_err_addr", m_err_addr, 5);
        check_eq("t3_valid", m_valid, 0);
        end_test();

        // 4: no-stop instance, errors at addr 2 and 6
        march(1'b1, -1, 0, 5, 13, cyc, nops, nruns, first);
        check_eq("t4_cycles", cyc, 37);
        check_eq("t4_ops", nops, 32);
        check_eq("t4_runs", nruns, 2);
        check_eq("t4_error", m_error, 1);
        check_eq("t4_err_addr", m_err_addr, 2);
        end_test();

        // 5: abort mid-EXEC; restart clears sticky error
        sel_b_dut = 1'b0;
        check_eq("t5_err_sticky", m_error, 1);
        check_eq("t5_err_addr_sticky", m_err_addr, 2);
        bist_en = 1'b1;
        @(negedge clk);
        check_eq("t5_err_cleared", m_error, 0);
        check_eq("t5_err_addr_cleared", m_err_addr, 0);
        check_eq("t5_busy", m_busy, 1);
        repeat (4) @(negedge clk);
        check_eq("t5_valid_running", m_valid, 1);
        bist_en = 1'b0;
        @(negedge clk);
        check_eq("t5_abort_valid", m_valid, 0);
        check_eq("t5_abort_busy", m_busy, 0);
        check_eq("t5_abort_done", m_done, 0);
        check_eq("t5_abort_run", m_run, 0);
        @(negedge clk);

        // 6a: first stimulus has op0 invalid
        sti_tab[0] = sti2(1'b0, OP_NONE, OP_NONE);
        sti_tab[1] = sti2(1'b0, OP_W0, OP_R0);
        num_sti = 2;
        march(1'b0, -1, 0, -1, -1, cyc, nops, nruns, first);
        check_eq("t6_cycles", cyc, 21);
        check_eq("t6_ops", nops, 16);
        check_eq("t6_runs", nruns, 2);
        check_eq("t6_latency", first, 4);
        end_test();

        // 6b: scan_shift mid-run
        bist_en = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("t6_valid_running", m_valid, 1);
        scan_shift = 1'b1;
        @(negedge clk);
        check_eq("t6_scan_valid", m_valid, 0);
        check_eq("t6_scan_busy", m_busy, 0);
        check_eq("t6_scan_done", m_done, 0);
        scan_shift = 1'b0;
        bist_en = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
